vec100_packer: RTL

// - Upstream feeder for the 100-bit vector stage: packs a stream of 32-bit beats

---
 rtl/vec_pkg.sv | 20 ++
 rtl/vec_out_slot.sv | 35 +++
 rtl/vec100_packer.sv | 73 +++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared widths and slice geometry for the 100-bit vector stage feeders.
package vec_pkg;

    localparam int W_IN  = 32;
    localparam int W_OUT = 100;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int BEATS  = ceil_div(W_OUT, W_IN);
    localparam int LAST_W = W_OUT - (BEATS - 1) * W_IN;
    localparam int CNT_W  = $clog2(BEATS);

    // Low bit position of beat k inside the frame (valid for k < BEATS-1).
    function automatic int offset(input int k);
        return W_OUT - (k + 1) * W_IN;
    endfunction

endpackage

// File: rtl/vec_out_slot.sv
// Single-entry valid/ready holding register; a load may coincide with a drain
// and then simply replaces the departing entry.
module vec_out_slot #(
    parameter int W = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_err,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         pad_err
);

    // NOTE: all state here is sequential, so only non-blocking assignments;
    // mixing in blocking ones would make readers in other blocks race.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            pad_err   <= 1'b0;
        end else begin
            pad_err <= load && load_err;
            if (load) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vec100_packer.sv
// Packs MSB-first 32-bit beats into 100-bit frames behind a one-entry output slot.
module vec100_packer
    import vec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [W_IN-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [W_OUT-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pad_err,
    output logic [15:0]      frame_cnt
);

    localparam int HI_W = W_OUT - LAST_W;

    logic [CNT_W-1:0] cnt;
    logic [HI_W-1:0]  asm_hi;
    logic             last_beat;
    logic             accept;
    logic             load;
    logic             pad_bad;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    // Only the final beat can stall: the earlier ones land in the assembly register.
    assign in_ready  = !abort && !(last_beat && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && last_beat;
    assign pad_bad   = |in_data[W_IN-1:LAST_W];

    // NOTE: the assembly register is cleared on reset and abort so a discarded
    // partial frame can never bleed into a later one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            asm_hi <= '0;
        end else if (abort || load) begin
            cnt    <= '0;
            asm_hi <= '0;
        end else if (accept) begin
            for (int k = 0; k < BEATS - 1; k++) begin
                if (cnt == CNT_W'(k)) begin
                    asm_hi[offset(k) - LAST_W +: W_IN] <= in_data;
                end
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

    vec_out_slot #(.W(W_OUT)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data ({asm_hi, in_data[LAST_W-1:0]}),
        .load_err  (pad_bad),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .pad_err   (pad_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (out_valid && out_ready) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
